// File: rtl/gpu_host_pkg.sv
// Shared types and constants for the host workgroup dispatch path.
// The descriptor layout is also consumed by the workgroup allocator.
package gpu_host_pkg;

    localparam int DESC_W         = 192;
    localparam int WG_ID_WIDTH    = 6;
    localparam int WF_COUNT_WIDTH = 6;

    // Packed descriptor field offsets, LSB first
    localparam int GDS_BASE_LSB  = 0;    // 32 bits
    localparam int GDS_SIZE_LSB  = 32;   // 12 bits
    localparam int LDS_SIZE_LSB  = 44;   // 12 bits
    localparam int SGPR_SIZE_LSB = 56;   // 12 bits
    localparam int VGPR_SIZE_LSB = 68;   // 12 bits
    localparam int CSR_KNL_LSB   = 80;   // 32 bits
    localparam int PDS_BASE_LSB  = 112;  // 32 bits
    localparam int START_PC_LSB  = 144;  // 32 bits
    localparam int WF_SIZE_LSB   = 176;  // 16 bits

    typedef struct packed {
        logic                      busy;
        logic                      done_pending;
        logic [WG_ID_WIDTH-1:0]    wg_id;
        logic [WF_COUNT_WIDTH-1:0] remaining;
    } slot_t;

    function automatic int lowest_set(input logic [31:0] v);
        lowest_set = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = i;
        end
    endfunction

    function automatic logic [DESC_W-1:0] pack_desc(
        input logic [15:0] wf_size,
        input logic [31:0] start_pc,
        input logic [31:0] pds_base,
        input logic [31:0] csr_knl,
        input logic [11:0] vgpr_size,
        input logic [11:0] sgpr_size,
        input logic [11:0] lds_size,
        input logic [11:0] gds_size,
        input logic [31:0] gds_base
    );
        pack_desc = '0;
        pack_desc[WF_SIZE_LSB   +: 16] = wf_size;
        pack_desc[START_PC_LSB  +: 32] = start_pc;
        pack_desc[PDS_BASE_LSB  +: 32] = pds_base;
        pack_desc[CSR_KNL_LSB   +: 32] = csr_knl;
        pack_desc[VGPR_SIZE_LSB +: 12] = vgpr_size;
        pack_desc[SGPR_SIZE_LSB +: 12] = sgpr_size;
        pack_desc[LDS_SIZE_LSB  +: 12] = lds_size;
        pack_desc[GDS_SIZE_LSB  +: 12] = gds_size;
        pack_desc[GDS_BASE_LSB  +: 32] = gds_base;
    endfunction

endpackage

// File: rtl/host_wg_intake_if.sv
// Host request/response, allocator dispatch and wavefront-completion signals
// seen by host_wg_intake; suffixes are from the intake block's point of view.
interface host_wg_intake_if #(
    parameter int DESC_W       = gpu_host_pkg::DESC_W,
    parameter int INFLIGHT_NUM = 8
);
    logic                                  host_req_valid_i;
    logic                                  host_req_ready_o;
    logic [gpu_host_pkg::WG_ID_WIDTH-1:0]    host_req_wg_id_i;
    logic [gpu_host_pkg::WF_COUNT_WIDTH-1:0] host_req_num_wf_i;
    logic [DESC_W-1:0]                     host_req_desc_i;
    logic                                  disp_valid_o;
    logic                                  disp_ready_i;
    logic [gpu_host_pkg::WG_ID_WIDTH-1:0]    disp_wg_id_o;
    logic [gpu_host_pkg::WF_COUNT_WIDTH-1:0] disp_num_wf_o;
    logic [DESC_W-1:0]                     disp_desc_o;
    logic                                  wf_done_valid_i;
    logic [gpu_host_pkg::WG_ID_WIDTH-1:0]    wf_done_wg_id_i;
    logic                                  host_rsp_valid_o;
    logic                                  host_rsp_ready_i;
    logic [gpu_host_pkg::WG_ID_WIDTH-1:0]    host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o;
    logic [$clog2(INFLIGHT_NUM+1)-1:0]     inflight_cnt_o;
    logic                                  err_o;

    modport slave (
        input  host_req_valid_i, host_req_wg_id_i, host_req_num_wf_i, host_req_desc_i,
        output host_req_ready_o,
        output disp_valid_o, disp_wg_id_o, disp_num_wf_o, disp_desc_o,
        input  disp_ready_i,
        input  wf_done_valid_i, wf_done_wg_id_i,
        output host_rsp_valid_o, host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
        input  host_rsp_ready_i,
        output inflight_cnt_o, err_o
    );

    modport master (
        output host_req_valid_i, host_req_wg_id_i, host_req_num_wf_i, host_req_desc_i,
        input  host_req_ready_o,
        input  disp_valid_o, disp_wg_id_o, disp_num_wf_o, disp_desc_o,
        output disp_ready_i,
        output wf_done_valid_i, wf_done_wg_id_i,
        input  host_rsp_valid_o, host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
        output host_rsp_ready_i,
        input  inflight_cnt_o, err_o
    );
endinterface

// File: rtl/host_req_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered ready flag;
// ready is low during reset and rises on the first edge after release.
module host_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             ready_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             ready_q;
    logic             full_d;

    assign wr_d    = wr_q + PW'(push_i);
    assign rd_d    = rd_q + PW'(pop_i);
    assign full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign ready_o = ready_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= !full_d;
            if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/host_wg_intake.sv
// Host workgroup intake: queues dispatch requests, tracks in-flight workgroups
// by wavefront completion count and returns finished wg_ids to the host.
module host_wg_intake #(
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int INFLIGHT_NUM   = 8,
    parameter int DESC_W         = gpu_host_pkg::DESC_W
) (
    input logic             clk,
    input logic             rst,
    host_wg_intake_if.slave bus
);
    import gpu_host_pkg::*;

    localparam int SLOT_W = (INFLIGHT_NUM > 1) ? $clog2(INFLIGHT_NUM) : 1;
    localparam int CNT_W  = $clog2(INFLIGHT_NUM + 1);
    localparam int ENT_W  = WG_ID_WIDTH + WF_COUNT_WIDTH + DESC_W;

    logic                      fifo_empty, fifo_ready;
    logic                      alloc, release_slot, rsp_load, bad_done, dup_err, multi;
    logic [ENT_W-1:0]          head;
    logic [WG_ID_WIDTH-1:0]    head_wg_id;
    logic [WF_COUNT_WIDTH-1:0] head_num_wf;
    logic [INFLIGHT_NUM-1:0]   free_vec, pend_vec, match_vec, dup_vec;
    logic [SLOT_W-1:0]         alloc_idx, pend_idx;
    slot_t                     slots_q [INFLIGHT_NUM];
    slot_t                     slots_d [INFLIGHT_NUM];
    logic                      rsp_valid_q, rsp_valid_d;
    logic [WG_ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
    logic                      err_q, err_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    host_req_fifo #(.WIDTH(ENT_W), .DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.host_req_valid_i && fifo_ready),
        .data_i  ({bus.host_req_wg_id_i, bus.host_req_num_wf_i, bus.host_req_desc_i}),
        .pop_i   (alloc),
        .data_o  (head),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

    assign {head_wg_id, head_num_wf, bus.disp_desc_o} = head;
    assign bus.host_req_ready_o = fifo_ready;
    assign bus.disp_wg_id_o     = head_wg_id;
    assign bus.disp_num_wf_o    = head_num_wf;

    always_comb begin
        for (int i = 0; i < INFLIGHT_NUM; i++) begin
            free_vec[i]  = !slots_q[i].busy;
            pend_vec[i]  = slots_q[i].busy && slots_q[i].done_pending;
            match_vec[i] = slots_q[i].busy && !slots_q[i].done_pending
                           && (slots_q[i].wg_id == bus.wf_done_wg_id_i);
            dup_vec[i]   = slots_q[i].busy && (slots_q[i].wg_id == head_wg_id);
        end
    end

    assign bus.disp_valid_o = !fifo_empty && (|free_vec);
    assign alloc            = bus.disp_valid_o && bus.disp_ready_i;
    assign alloc_idx        = SLOT_W'(lowest_set(32'(free_vec)));
    assign pend_idx         = SLOT_W'(lowest_set(32'(pend_vec)));
    assign rsp_load         = !rsp_valid_q || bus.host_rsp_ready_i;
    assign release_slot     = rsp_load && (|pend_vec);
    assign multi            = |(match_vec & (match_vec - INFLIGHT_NUM'(1)));
    assign bad_done         = bus.wf_done_valid_i && ((match_vec == '0) || multi);
    assign dup_err          = alloc && (|dup_vec);
    assign err_d            = err_q || bad_done || dup_err;
    assign cnt_d            = cnt_q + CNT_W'(alloc) - CNT_W'(release_slot);

    // Decrement, release and allocation never touch the same slot in one cycle
    always_comb begin
        slots_d = slots_q;
        if (bus.wf_done_valid_i && !bad_done) begin
            for (int i = 0; i < INFLIGHT_NUM; i++) begin
                if (match_vec[i]) begin
                    slots_d[i].remaining = slots_q[i].remaining - WF_COUNT_WIDTH'(1);
                    if (slots_q[i].remaining == WF_COUNT_WIDTH'(1)) slots_d[i].done_pending = 1'b1;
                end
            end
        end
        if (release_slot) slots_d[pend_idx] = '0;
        if (alloc) begin
            slots_d[alloc_idx].busy         = 1'b1;
            slots_d[alloc_idx].done_pending = (head_num_wf == '0);
            slots_d[alloc_idx].wg_id        = head_wg_id;
            slots_d[alloc_idx].remaining    = head_num_wf;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        if (rsp_load) begin
            rsp_valid_d = release_slot;
            if (release_slot) rsp_id_d = slots_q[pend_idx].wg_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INFLIGHT_NUM; i++) slots_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            slots_q     <= slots_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.host_rsp_valid_o = rsp_valid_q;
    assign bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o = rsp_id_q;
    assign bus.inflight_cnt_o   = cnt_q;
    assign bus.err_o            = err_q;
endmodule

// File: tb/tb_host_wg_intake.sv
// Directed bench for host_wg_intake: dispatch, backpressure, table-full,
// concurrent events, edge cases and mid-operation reset.
module tb_host_wg_intake;
    import gpu_host_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rsp_seen;

    always #5 clk = ~clk;

    host_wg_intake_if #(.DESC_W(DESC_W), .INFLIGHT_NUM(8)) bus ();

    host_wg_intake #(.REQ_FIFO_DEPTH(4), .INFLIGHT_NUM(8), .DESC_W(DESC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DESC_W-1:0] mk_desc(input int id);
        return pack_desc(16'(64), 32'h1000 + 32'(id), 32'h2000 + 32'(id), 32'hC5C5_0000 + 32'(id),
                         12'(id + 1), 12'(id + 2), 12'(id + 3), 12'(id + 4), 32'hABCD_0000 + 32'(id));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int nwf);
        bus.host_req_valid_i  = 1'b1;
        bus.host_req_wg_id_i  = WG_ID_WIDTH'(id);
        bus.host_req_num_wf_i = WF_COUNT_WIDTH'(nwf);
        bus.host_req_desc_i   = mk_desc(id);
        for (int i = 0; i < 50; i++) begin
            if (bus.host_req_ready_o) break;
            step();
        end
        check_eq("push_ready", 64'(bus.host_req_ready_o), 64'(1));
        step();
        bus.host_req_valid_i = 1'b0;
    endtask

    task automatic wf_done(input int id);
        bus.wf_done_valid_i = 1'b1;
        bus.wf_done_wg_id_i = WG_ID_WIDTH'(id);
        step();
        bus.wf_done_valid_i = 1'b0;
    endtask

    task automatic rsp_handshake();
        bus.host_rsp_ready_i = 1'b1;
        step();
        bus.host_rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DESC_W-1:0] d;
        bus.host_req_valid_i  = 1'b0;
        bus.host_req_wg_id_i  = '0;
        bus.host_req_num_wf_i = '0;
        bus.host_req_desc_i   = '0;
        bus.disp_ready_i      = 1'b0;
        bus.wf_done_valid_i   = 1'b0;
        bus.wf_done_wg_id_i   = '0;
        bus.host_rsp_ready_i  = 1'b0;

        // Reset state
        step(); step();
        check_eq("rst_ready", 64'(bus.host_req_ready_o), 64'(0));
        check_eq("rst_disp_valid", 64'(bus.disp_valid_o), 64'(0));
        check_eq("rst_rsp_valid", 64'(bus.host_rsp_valid_o), 64'(0));
        check_eq("rst_cnt", 64'(bus.inflight_cnt_o), 64'(0));
        check_eq("rst_err", 64'(bus.err_o), 64'(0));
        rst = 1'b0;
        check_eq("ready_before_edge", 64'(bus.host_req_ready_o), 64'(0));
        step();
        check_eq("ready_after_edge", 64'(bus.host_req_ready_o), 64'(1));

        // Single WG 5 with 4 wavefronts
        bus.disp_ready_i = 1'b1;
        push(5, 4);
        d = mk_desc(5);
        check_eq("t1_disp_valid", 64'(bus.disp_valid_o), 64'(1));
        check_eq("t1_disp_id", 64'(bus.disp_wg_id_o), 64'(5));
        check_eq("t1_disp_nwf", 64'(bus.disp_num_wf_o), 64'(4));
        check_eq("t1_desc_lo", bus.disp_desc_o[63:0], d[63:0]);
        check_eq("t1_desc_hi", bus.disp_desc_o[191:128], d[191:128]);
        check_eq("t1_cnt0", 64'(bus.inflight_cnt_o), 64'(0));
        step();
        check_eq("t1_cnt1", 64'(bus.inflight_cnt_o), 64'(1));
        check_eq("t1_disp_idle", 64'(bus.disp_valid_o), 64'(0));
        for (int k = 0; k < 4; k++) wf_done(5);
        check_eq("t1_rsp_not_yet", 64'(bus.host_rsp_valid_o), 64'(0));
        step();
        check_eq("t1_rsp_valid", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t1_rsp_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(5));
        step();
        check_eq("t1_rsp_hold", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t1_rsp_hold_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(5));
        rsp_handshake();
        check_eq("t1_rsp_done", 64'(bus.host_rsp_valid_o), 64'(0));
        check_eq("t1_cnt_end", 64'(bus.inflight_cnt_o), 64'(0));

        // Backpressure: 5 requests into a 4-deep FIFO
        bus.disp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.host_req_valid_i  = 1'b1;
            bus.host_req_wg_id_i  = WG_ID_WIDTH'(k);
            bus.host_req_num_wf_i = WF_COUNT_WIDTH'(1);
            bus.host_req_desc_i   = mk_desc(k);
            step();
        end
        check_eq("t2_full_ready", 64'(bus.host_req_ready_o), 64'(0));
        bus.host_req_wg_id_i = WG_ID_WIDTH'(4);
        bus.host_req_desc_i  = mk_desc(4);
        step();
        check_eq("t2_still_full", 64'(bus.host_req_ready_o), 64'(0));
        check_eq("t2_head0", 64'(bus.disp_wg_id_o), 64'(0));
        check_eq("t2_valid_held", 64'(bus.disp_valid_o), 64'(1));
        bus.disp_ready_i = 1'b1;
        step();
        check_eq("t2_ready_back", 64'(bus.host_req_ready_o), 64'(1));
        check_eq("t2_head1", 64'(bus.disp_wg_id_o), 64'(1));
        step();
        bus.host_req_valid_i = 1'b0;
        for (int k = 2; k < 5; k++) begin
            check_eq($sformatf("t2_head%0d", k), 64'(bus.disp_wg_id_o), 64'(k));
            step();
        end
        check_eq("t2_drained", 64'(bus.disp_valid_o), 64'(0));
        check_eq("t2_cnt5", 64'(bus.inflight_cnt_o), 64'(5));
        for (int k = 0; k < 5; k++) wf_done(k);
        bus.host_rsp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_rsp_valid%0d", k), 64'(bus.host_rsp_valid_o), 64'(1));
            check_eq($sformatf("t2_rsp_id%0d", k),
                     64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(k));
            step();
        end
        bus.host_rsp_ready_i = 1'b0;
        check_eq("t2_rsp_empty", 64'(bus.host_rsp_valid_o), 64'(0));
        check_eq("t2_cnt0", 64'(bus.inflight_cnt_o), 64'(0));

        // Table full: WG 8 waits for a free slot
        for (int k = 0; k < 9; k++) push(k, 1);
        step();
        check_eq("t3_cnt8", 64'(bus.inflight_cnt_o), 64'(8));
        check_eq("t3_blocked", 64'(bus.disp_valid_o), 64'(0));
        check_eq("t3_head8", 64'(bus.disp_wg_id_o), 64'(8));
        wf_done(3);
        check_eq("t3_still_blocked", 64'(bus.disp_valid_o), 64'(0));
        step();
        check_eq("t3_rsp3", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(3));
        check_eq("t3_unblocked", 64'(bus.disp_valid_o), 64'(1));
        rsp_handshake();
        check_eq("t3_cnt_refill", 64'(bus.inflight_cnt_o), 64'(8));
        check_eq("t3_disp_taken", 64'(bus.disp_valid_o), 64'(0));
        check_eq("t3_rsp_clear", 64'(bus.host_rsp_valid_o), 64'(0));

        // Simultaneous final wf_done(2), rsp handshake of WG 1, dispatch of WG 9
        wf_done(1);
        step();
        check_eq("t4_rsp1", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(1));
        bus.disp_ready_i = 1'b0;
        push(9, 1);
        check_eq("t4_disp9", 64'(bus.disp_wg_id_o), 64'(9));
        bus.wf_done_valid_i  = 1'b1;
        bus.wf_done_wg_id_i  = WG_ID_WIDTH'(2);
        bus.host_rsp_ready_i = 1'b1;
        bus.disp_ready_i     = 1'b1;
        step();
        bus.wf_done_valid_i  = 1'b0;
        bus.host_rsp_ready_i = 1'b0;
        check_eq("t4_cnt", 64'(bus.inflight_cnt_o), 64'(8));
        check_eq("t4_rsp_gap", 64'(bus.host_rsp_valid_o), 64'(0));
        check_eq("t4_disp_done", 64'(bus.disp_valid_o), 64'(0));
        check_eq("t4_err", 64'(bus.err_o), 64'(0));
        step();
        check_eq("t4_rsp2_valid", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t4_rsp2_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(2));
        foreach (d[i]) d[i] = 1'b0;
        wf_done(0); wf_done(4); wf_done(5); wf_done(6); wf_done(7); wf_done(8); wf_done(9);
        rsp_seen = 0;
        bus.host_rsp_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (bus.host_rsp_valid_o) rsp_seen++;
            step();
        end
        bus.host_rsp_ready_i = 1'b0;
        check_eq("t4_rsp_count", 64'(rsp_seen), 64'(8));
        check_eq("t4_cnt0", 64'(bus.inflight_cnt_o), 64'(0));
        check_eq("t4_err_end", 64'(bus.err_o), 64'(0));

        // num_wf == 0 completes without any wf_done
        push(7, 0);
        step();
        check_eq("t5_cnt1", 64'(bus.inflight_cnt_o), 64'(1));
        check_eq("t5_rsp_not_yet", 64'(bus.host_rsp_valid_o), 64'(0));
        step();
        check_eq("t5_rsp_valid", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t5_rsp_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(7));
        rsp_handshake();
        check_eq("t5_cnt0", 64'(bus.inflight_cnt_o), 64'(0));

        // Unknown id 30 flags err and leaves WG 11 untouched
        push(11, 2);
        step();
        check_eq("t6_err_pre", 64'(bus.err_o), 64'(0));
        wf_done(30);
        check_eq("t6_err", 64'(bus.err_o), 64'(1));
        check_eq("t6_cnt", 64'(bus.inflight_cnt_o), 64'(1));
        wf_done(11);
        step();
        check_eq("t6_rsp_not_yet", 64'(bus.host_rsp_valid_o), 64'(0));
        wf_done(11);
        step();
        check_eq("t6_rsp_valid", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t6_rsp_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(11));
        rsp_handshake();

        // Mid-operation reset with WGs in flight and a pending response
        push(20, 2); push(21, 2); push(22, 2); push(23, 0);
        step(); step(); step();
        check_eq("t7_cnt3", 64'(bus.inflight_cnt_o), 64'(3));
        check_eq("t7_rsp_pending", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t7_err_sticky", 64'(bus.err_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("t7_async_rsp", 64'(bus.host_rsp_valid_o), 64'(0));
        check_eq("t7_async_cnt", 64'(bus.inflight_cnt_o), 64'(0));
        check_eq("t7_async_err", 64'(bus.err_o), 64'(0));
        check_eq("t7_async_ready", 64'(bus.host_req_ready_o), 64'(0));
        check_eq("t7_async_disp", 64'(bus.disp_valid_o), 64'(0));
        step();
        rst = 1'b0;
        step();
        check_eq("t7_ready_again", 64'(bus.host_req_ready_o), 64'(1));
        push(0, 1);
        step();
        wf_done(0);
        step();
        check_eq("t7_rsp_valid", 64'(bus.host_rsp_valid_o), 64'(1));
        check_eq("t7_rsp_id", 64'(bus.host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o), 64'(0));
        rsp_handshake();
        check_eq("t7_cnt0", 64'(bus.inflight_cnt_o), 64'(0));
        check_eq("t7_err0", 64'(bus.err_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/host_wg_intake.md
Name: host_wg_intake

Overview:
- GPU-side responder to the host workgroup dispatch interface.
- Accepts host_req descriptors into a request FIFO and forwards them to the workgroup allocator over a valid/ready port.
- Tracks in-flight workgroups and counts wavefront completions reported by the CUs.
- Returns the wg_id of each fully finished workgroup on the host_rsp handshake.

Parameters:
- REQ_FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.
- INFLIGHT_NUM, 8: tracking-table slots, i.e. the maximum number of concurrently dispatched workgroups.
- DESC_W, 192: width of the packed descriptor carried with each request.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- host_req_valid_i  in  1  host request valid
- host_req_ready_o  out  1  request FIFO not full
- host_req_wg_id_i  in  `WG_ID_WIDTH  workgroup id
- host_req_num_wf_i  in  `WF_COUNT_WIDTH  wavefronts in this workgroup
- host_req_desc_i  in  DESC_W  packed {wf_size, start_pc, pds_baseaddr, csr_knl, vgpr/sgpr/lds/gds sizes, gds_baseaddr}
- disp_valid_o  out  1  descriptor valid toward the allocator
- disp_ready_i  in  1  allocator accepts
- disp_wg_id_o  out  `WG_ID_WIDTH  forwarded id
- disp_num_wf_o  out  `WF_COUNT_WIDTH  forwarded count
- disp_desc_o  out  DESC_W  forwarded descriptor
- wf_done_valid_i  in  1  one wavefront finished (single-cycle pulse)
- wf_done_wg_id_i  in  `WG_ID_WIDTH  owner workgroup of that wavefront
- host_rsp_valid_o  out  1  finished workgroup available
- host_rsp_ready_i  in  1  host accepts
- host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o  out  `WG_ID_WIDTH  finished wg_id
- inflight_cnt_o  out  $clog2(INFLIGHT_NUM+1)  occupied tracking slots
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values: all valids 0, host_req_ready_o 0, data outputs 0, FIFO empty, table cleared, err_o 0.
  - host_req_ready_o rises on the first clk edge after rst deasserts.
  - rst asserted mid-operation drops everything immediately, including in-flight workgroups and pending responses.
- Request FIFO:
  - A push occurs on host_req_valid_i && host_req_ready_o.
  - host_req_ready_o = !full, registered-equivalent and independent of host_req_valid_i.
  - Push and pop in the same cycle while full is not allowed, because ready is already 0.
  - Push and pop in the same cycle while empty is not bypassed: there is a minimum 1-cycle latency from accept to disp_valid_o.
  - Pointers are $clog2(depth)+1 bits with wrap bit; full/empty are derived from the pointer compare.
- Dispatch:
  - disp_valid_o = !fifo_empty && free_slot_exists.
  - disp_* outputs are the FIFO head.
  - On disp_valid_o && disp_ready_i: pop the FIFO and allocate the lowest free slot {busy=1, wg_id, remaining=num_wf}.
  - If num_wf==0, the slot is allocated with done_pending=1 instead.
  - Once disp_valid_o is high, it and its data stay stable until accepted.
  - Exception: if the last free slot is taken, valid cannot drop, because only this block allocates slots.
- Completion:
  - On wf_done_valid_i, CAM-match wf_done_wg_id_i against busy slots whose done_pending==0, and decrement remaining.
  - When remaining goes 1→0, set done_pending.
  - No match, or multiple matches, sets err_o (sticky until rst); the pulse is otherwise ignored.
  - A duplicate wg_id accepted at dispatch while another copy is busy also sets err_o.
- Response:
  - Single response register.
  - When host_rsp_valid_o==0 or the handshake completes this cycle, load the lowest-index done_pending slot, then clear that slot's busy and done_pending.
  - host_rsp_valid_o=1 holds with stable data until host_rsp_ready_i.
- Same-cycle ordering:
  - wf_done decrement, dispatch allocation and response load may all occur in one cycle.
  - A slot freed by a response load is usable by dispatch only in the following cycle.
  - A slot reaching done_pending this cycle is eligible for response load next cycle, giving 1-cycle completion-to-valid latency.
- inflight_cnt_o counts busy slots, updated each cycle (+alloc −release).

Decomposition:
- Package gpu_host_pkg:
  - DESC_W and the field-offset constants of the packed descriptor, shared with the allocator.
  - Slot struct {busy, done_pending, wg_id, remaining}.
  - Lowest-set-bit priority-encoder function.
- Sub-module: host_req_fifo (parameterized sync FIFO, async active-high reset), instantiated once for the request path.
- Tracking table and response logic stay in the top module.

Test Plan:
- Single WG, id 5, num_wf=4, disp_ready_i=1:
  - disp_valid_o rises 1 cycle after accept.
  - After the fourth wf_done(5), host_rsp_valid_o rises next cycle with id 5.
  - inflight_cnt_o returns to 0 after the host handshake.
- Backpressure, disp_ready_i=0, 5 pushes with REQ_FIFO_DEPTH=4:
  - host_req_ready_o drops after the 4th push.
  - The 5th request is held until one pop, then accepted.
  - Order 0..4 is preserved at disp_*.
- Table full, INFLIGHT_NUM=8, 9 WGs dispatched with no completions:
  - disp_valid_o=0 for WG 8.
  - Finish WG 3 and complete its host handshake; WG 8 dispatches the cycle after the release.
- Simultaneous events: in one cycle, final wf_done for WG 2, host_rsp handshake of WG 1, and a new dispatch of WG 9:
  - All take effect.
  - WG 2 response appears the next cycle.
  - No err_o.
- Edge cases:
  - num_wf=0 for WG 7 yields a response without any wf_done.
  - wf_done for unknown id 30 sets err_o; other state is unchanged.
- Reset mid-operation with 3 WGs in flight and host_rsp_valid_o=1:
  - Outputs clear asynchronously.
  - After release, a new WG 0 completes normally.
